// File: rtl/toi2s_pkg.sv
// Shared types and constants for the DSP configuration sequencer.
// Defines the config word layout, the sequencer states and the compared field.
package toi2s_pkg;

  localparam int unsigned DSP_CFG_W          = 8;
  localparam int unsigned DSP_CFG_ACTIVE_MSB = 7;
  localparam int unsigned DSP_CFG_ACTIVE_LSB = 3;

  // Register-bank DSP configuration word; rsvd bits ride along but never trigger a sequence
  typedef struct packed {
    logic       bypass;
    logic       dc;
    logic       bp;
    logic       dec;
    logic       pli;
    logic [2:0] rsvd;
  } rb_dsp_cfg_wire_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_DOWN = 3'd1,
    FLUSH     = 3'd2,
    APPLY     = 3'd3,
    MUTED     = 3'd4,
    RAMP_UP   = 3'd5
  } dsp_seq_state_t;

  function automatic logic cfg_active_diff(input rb_dsp_cfg_wire_t a, input rb_dsp_cfg_wire_t b);
    logic [DSP_CFG_W-1:0] va;
    logic [DSP_CFG_W-1:0] vb;
    va = a;
    vb = b;
    return va[DSP_CFG_ACTIVE_MSB:DSP_CFG_ACTIVE_LSB] != vb[DSP_CFG_ACTIVE_MSB:DSP_CFG_ACTIVE_LSB];
  endfunction

endpackage

// File: rtl/dsp_gain_ramp.sv
// Gain register with saturating per-strobe step up/down and clear.
// Also flags when the next step would land on zero or full scale.
module dsp_gain_ramp #(
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              i_up,
  input  logic              i_down,
  input  logic              i_clr,
  output logic [GAIN_W-1:0] o_gain,
  output logic              o_at_zero,
  output logic              o_at_full,
  output logic              o_last_down,
  output logic              o_last_up
);

  localparam logic [GAIN_W:0]   FULL_X = {1'b0, {GAIN_W{1'b1}}};
  localparam logic [GAIN_W:0]   STEP_X = (GAIN_W+1)'(RAMP_STEP);
  localparam logic [GAIN_W-1:0] STEP   = GAIN_W'(RAMP_STEP);

  logic [GAIN_W-1:0] r_gain;
  logic [GAIN_W:0]   w_sum;
  logic              w_last_up;
  logic              w_last_down;

  // One extra carry bit so the add can never wrap past full scale
  assign w_sum       = {1'b0, r_gain} + STEP_X;
  assign w_last_up   = (w_sum >= FULL_X);
  assign w_last_down = ({1'b0, r_gain} <= STEP_X);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_gain <= '0;
    end else if (i_clr) begin
      r_gain <= '0;
    end else if (i_down) begin
      r_gain <= w_last_down ? '0 : (r_gain - STEP);
    end else if (i_up) begin
      r_gain <= w_last_up ? '1 : w_sum[GAIN_W-1:0];
    end
  end

  assign o_gain      = r_gain;
  assign o_at_zero   = (r_gain == '0);
  assign o_at_full   = (r_gain == '1);
  assign o_last_down = w_last_down;
  assign o_last_up   = w_last_up;

endmodule

// File: rtl/dsp_cfg_sequencer.sv
// Mutes the DSP gain around configuration changes so new settings never land mid-signal.
// Ramp down, flush at zero gain, apply the new config, ramp back up; paced by the sample strobe.
module dsp_cfg_sequencer
  import toi2s_pkg::*;
#(
  parameter int unsigned      GAIN_W        = 8,
  parameter int unsigned      RAMP_STEP     = 16,
  parameter int unsigned      FLUSH_SAMPLES = 4,
  parameter rb_dsp_cfg_wire_t RESET_CFG     = 8'h00
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              sample_strb_i,
  input  logic              enable_i,
  input  rb_dsp_cfg_wire_t  rb_dsp_cfg_i,
  output rb_dsp_cfg_wire_t  dsp_cfg_o,
  output logic [GAIN_W-1:0] gain_o,
  output logic              busy_o,
  output logic              cfg_applied_o
);

  localparam int unsigned     CNT_W      = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_SAMPLES - 1);

  dsp_seq_state_t   r_state;
  dsp_seq_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;
  rb_dsp_cfg_wire_t r_cfg;
  rb_dsp_cfg_wire_t w_cfg_nxt;
  logic             r_applied;
  logic             w_applied_nxt;
  logic             r_busy;

  logic w_diff;
  logic w_up;
  logic w_down;
  logic w_clr;
  logic w_at_zero;
  logic w_at_full;
  logic w_last_down;
  logic w_last_up;

  assign w_diff = cfg_active_diff(rb_dsp_cfg_i, r_cfg);

  dsp_gain_ramp #(
    .GAIN_W    (GAIN_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_gain_ramp (
    .clk         (clk),
    .resetb      (resetb),
    .i_up        (w_up),
    .i_down      (w_down),
    .i_clr       (w_clr),
    .o_gain      (gain_o),
    .o_at_zero   (w_at_zero),
    .o_at_full   (w_at_full),
    .o_last_down (w_last_down),
    .o_last_up   (w_last_up)
  );

  // Reset lands in RAMP_UP from zero gain for a soft start
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= RAMP_UP;
      r_flush_cnt <= '0;
      r_cfg       <= RESET_CFG;
      r_applied   <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_cfg       <= w_cfg_nxt;
      r_applied   <= w_applied_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_cfg_nxt       = r_cfg;
    w_applied_nxt   = 1'b0;
    w_up            = 1'b0;
    w_down          = 1'b0;
    w_clr           = 1'b0;

    if (sample_strb_i) begin
      case (r_state)
        IDLE: begin
          if (!enable_i || w_diff) w_state_nxt = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          w_down = 1'b1;
          if (w_last_down) begin
            w_state_nxt     = FLUSH;
            w_flush_cnt_nxt = FLUSH_INIT;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) w_state_nxt = APPLY;
          else                   w_flush_cnt_nxt = r_flush_cnt - CNT_W'(1);
        end
        APPLY: begin
          w_clr         = !w_at_zero;
          w_cfg_nxt     = rb_dsp_cfg_i;
          w_applied_nxt = 1'b1;
          w_state_nxt   = enable_i ? RAMP_UP : MUTED;
        end
        MUTED: begin
          // Output is silent, so a config change is loaded without a flush
          w_clr = !w_at_zero;
          if (w_diff) begin
            w_cfg_nxt     = rb_dsp_cfg_i;
            w_applied_nxt = 1'b1;
          end
          if (enable_i) w_state_nxt = RAMP_UP;
        end
        RAMP_UP: begin
          if (!enable_i || w_diff) begin
            w_state_nxt = RAMP_DOWN;
          end else if (w_at_full) begin
            w_state_nxt = IDLE;
          end else begin
            w_up = 1'b1;
            if (w_last_up) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = RAMP_UP;
      endcase
    end
  end

  assign dsp_cfg_o     = r_cfg;
  assign busy_o        = r_busy;
  assign cfg_applied_o = r_applied;

endmodule

// File: tb/tb_dsp_cfg_sequencer.sv
// Scoreboard bench for dsp_cfg_sequencer: per-strobe expected outputs are queued as
// each scenario is set up, then popped and compared after every strobe edge.
module tb_dsp_cfg_sequencer;

  localparam int unsigned FULL    = 255;
  localparam int unsigned STEP    = 16;
  localparam int unsigned FLUSH_N = 4;

  logic       clk           = 1'b0;
  logic       resetb        = 1'b1;
  logic       sample_strb_i = 1'b0;
  logic       enable_i      = 1'b1;
  logic [7:0] rb_dsp_cfg_i  = 8'h00;
  logic [7:0] dsp_cfg_o;
  logic [7:0] gain_o;
  logic       busy_o;
  logic       cfg_applied_o;

  typedef struct packed {
    logic [7:0] gain;
    logic [7:0] cfg;
    logic       busy;
    logic       applied;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  dsp_cfg_sequencer dut (
    .clk           (clk),
    .resetb        (resetb),
    .sample_strb_i (sample_strb_i),
    .enable_i      (enable_i),
    .rb_dsp_cfg_i  (rb_dsp_cfg_i),
    .dsp_cfg_o     (dsp_cfg_o),
    .gain_o        (gain_o),
    .busy_o        (busy_o),
    .cfg_applied_o (cfg_applied_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t act=%0h exp=%0h", tag, $time, act, exp);
  endtask

  task automatic push(input int unsigned g, input logic [7:0] c, input logic b, input logic a);
    exp_t e;
    e.gain    = 8'(g);
    e.cfg     = c;
    e.busy    = b;
    e.applied = a;
    sb_q.push_back(e);
  endtask

  task automatic push_up(input int unsigned g0, input logic [7:0] c);
    int unsigned g;
    g = g0;
    while (g < FULL) begin
      g = (g + STEP > FULL) ? FULL : g + STEP;
      push(g, c, g != FULL, 1'b0);
    end
  endtask

  task automatic push_down(input int unsigned g0, input logic [7:0] c);
    int unsigned g;
    g = g0;
    do begin
      g = (g > STEP) ? g - STEP : 0;
      push(g, c, 1'b1, 1'b0);
    end while (g != 0);
  endtask

  task automatic push_flush(input logic [7:0] c);
    repeat (FLUSH_N) push(0, c, 1'b1, 1'b0);
  endtask

  // One strobe every 4 clocks; outputs sampled 1 time unit after the strobe edge
  task automatic strobe_check();
    exp_t e;
    @(negedge clk);
    sample_strb_i = 1'b1;
    @(posedge clk);
    #1;
    sample_strb_i = 1'b0;
    e = sb_q.pop_front();
    check("gain",    32'(gain_o),        32'(e.gain));
    check("cfg",     32'(dsp_cfg_o),     32'(e.cfg));
    check("busy",    32'(busy_o),        32'(e.busy));
    check("applied", 32'(cfg_applied_o), 32'(e.applied));
    @(posedge clk);
    #1;
    if (e.applied) check("applied_len", 32'(cfg_applied_o), 32'd0);
    check("hold_gain", 32'(gain_o), 32'(e.gain));
    repeat (2) @(posedge clk);
  endtask

  task automatic drain();
    while (sb_q.size() != 0) strobe_check();
  endtask

  initial begin
    #2 resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gain",    32'(gain_o),        32'd0);
    check("rst_cfg",     32'(dsp_cfg_o),     32'h00);
    check("rst_busy",    32'(busy_o),        32'd1);
    check("rst_applied", 32'(cfg_applied_o), 32'd0);
    @(negedge clk);
    resetb = 1'b1;

    // Soft start
    push_up(0, 8'h00);
    drain();

    // Active field change from IDLE
    rb_dsp_cfg_i = 8'h80;
    push(FULL, 8'h00, 1'b1, 1'b0);
    push_down(FULL, 8'h00);
    push_flush(8'h00);
    push(0, 8'h80, 1'b1, 1'b1);
    push_up(0, 8'h80);
    drain();

    // Reserved-bits-only change: no sequence
    rb_dsp_cfg_i = 8'h87;
    repeat (3) push(FULL, 8'h80, 1'b0, 1'b0);
    drain();

    // Disable -> MUTED, load while muted, then re-enable
    enable_i = 1'b0;
    push(FULL, 8'h80, 1'b1, 1'b0);
    push_down(FULL, 8'h80);
    push_flush(8'h80);
    push(0, 8'h87, 1'b1, 1'b1);
    push(0, 8'h87, 1'b1, 1'b0);
    drain();
    rb_dsp_cfg_i = 8'h40;
    push(0, 8'h40, 1'b1, 1'b1);
    push(0, 8'h40, 1'b1, 1'b0);
    drain();
    enable_i = 1'b1;
    push(0, 8'h40, 1'b1, 1'b0);
    push_up(0, 8'h40);
    drain();

    // Reversal during ramp up at gain 128
    rb_dsp_cfg_i = 8'h48;
    push(FULL, 8'h40, 1'b1, 1'b0);
    push_down(FULL, 8'h40);
    push_flush(8'h40);
    push(0, 8'h48, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) push(k * STEP, 8'h48, 1'b1, 1'b0);
    drain();
    rb_dsp_cfg_i = 8'h10;
    push(128, 8'h48, 1'b1, 1'b0);
    push_down(128, 8'h48);
    push_flush(8'h48);
    push(0, 8'h10, 1'b1, 1'b1);
    push_up(0, 8'h10);
    drain();

    // Async reset in the middle of FLUSH
    rb_dsp_cfg_i = 8'h18;
    push(FULL, 8'h10, 1'b1, 1'b0);
    push_down(FULL, 8'h10);
    push(0, 8'h10, 1'b1, 1'b0);
    push(0, 8'h10, 1'b1, 1'b0);
    drain();
    #2 resetb = 1'b0;
    #1;
    check("mid_rst_gain",    32'(gain_o),        32'd0);
    check("mid_rst_cfg",     32'(dsp_cfg_o),     32'h00);
    check("mid_rst_busy",    32'(busy_o),        32'd1);
    check("mid_rst_applied", 32'(cfg_applied_o), 32'd0);
    rb_dsp_cfg_i = 8'h00;
    @(negedge clk);
    resetb = 1'b1;
    push_up(0, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
